pc_update: RTL and testbench
============================

# pc_update

Program-counter register and next-PC stage of the core. Sits directly downstream of the execute unit's branch-condition logic: it consumes the `PCAsrc`/`PCBsrc` select pair together with the immediate and rs1 operands, forms the next PC, and hands each PC to the fetch unit over a valid/ready handshake. It also detects misaligned targets and counts retired instructions.

## Interface
Parameters:
- `XLEN`, 32: datapath and PC width.
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ifu_valid`  out  1  `ifu_pc` is offered to fetch.
- `ifu_ready`  in  1  fetch accepts `ifu_pc`.
- `ifu_pc`  out  XLEN  PC of the instruction to fetch.
- `exu_valid`  in  1  execute has finished the current instruction; select and operand inputs are valid.
- `exu_ready`  out  1  stage is waiting for the execute result.
- `pca_src`  in  1  0: addend A = 4; 1: addend A = `exu_imm`.
- `pcb_src`  in  1  0: addend B = current PC; 1: addend B = `exu_rs1`.
- `exu_imm`  in  XLEN  sign-extended immediate.
- `exu_rs1`  in  XLEN  rs1 value.
- `misalign`  out  1  sticky flag: a computed target had `[1:0] != 0`.
- `misalign_pc`  out  XLEN  the offending target; 0 unless `misalign` is set.
- `retire_cnt`  out  64  count of instructions whose next PC was committed.

## Operation
- State machine: ISSUE, WAIT, HALT.
- ISSUE:
  - `ifu_valid`=1.
  - On `ifu_valid & ifu_ready`, go to WAIT.
  - `ifu_pc` stays stable while `ifu_ready`=0.
- WAIT:
  - `exu_ready`=1 and `ifu_valid`=0.
  - On `exu_valid`, compute `target = (pca_src ? exu_imm : 4) + (pcb_src ? exu_rs1 : pc)`, modulo 2^XLEN. Carry-out is discarded, so wrap-around past all-ones is legal.
  - If `pcb_src`=1 (register-indirect jump), clear `target[0]` after the add.
  - If `target[1:0]==0`: `pc<=target`, `retire_cnt` increments by 1, next state ISSUE.
  - Otherwise: `pc` is unchanged, `misalign<=1`, `misalign_pc<=target`, `retire_cnt` is unchanged, next state HALT.
- HALT: `ifu_valid`=0 and `exu_ready`=0. The stage stays in HALT until reset.
- `exu_valid` outside WAIT is ignored. The select and operand inputs are sampled only in the WAIT cycle where `exu_valid`=1.
- `retire_cnt` wraps from 2^64-1 to 0.
- `ifu_pc` always equals the `pc` register.

## Timing
- Reset (synchronous, sampled at the clock edge):
  - `pc`=`RESET_PC`, state=ISSUE, `misalign`=0, `misalign_pc`=0, `retire_cnt`=0.
  - `ifu_valid`=0 and `exu_ready`=0 in any cycle where `reset`=1.
  - First cycle after reset deasserts: `ifu_valid`=1, `ifu_pc`=`RESET_PC`.
- Reset overrides all activity, including mid-WAIT, mid-ISSUE and HALT. A coincident `exu_valid` or `ifu_ready` in a reset cycle has no effect.
- Outputs are decoded from registered state only. `ifu_valid` and `exu_ready` have no combinational path from `ifu_ready` or `exu_valid`.
- ISSUE→WAIT: the handshake edge.
- WAIT→ISSUE: the `exu_valid` edge. The new `ifu_pc` is visible in the next cycle.
- Minimum loop with both partners always ready: 2 cycles per instruction.
- `misalign` and `misalign_pc` become visible in the cycle after the offending `exu_valid`.

## Test plan
- Reset, then hold `ifu_ready`=1, `exu_valid`=1, `pca_src`=0, `pcb_src`=0 -> `ifu_pc` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, one new PC every 2 cycles; `retire_cnt`=3 after 3 commits.
- Fetch backpressure: `ifu_ready`=0 for 5 cycles -> `ifu_valid`=1 and `ifu_pc` constant throughout; `exu_ready`=0; `exu_valid` pulses are ignored with no PC change.
- Taken branch: pc=0x8000_0010, `pca_src`=1, `pcb_src`=0, `exu_imm`=0xFFFF_FFF0 -> next `ifu_pc`=0x8000_0000. Wrap case: pc=0xFFFF_FFFC with +4 -> 0x0000_0000.
- Indirect jump: `pca_src`=1, `pcb_src`=1, `exu_rs1`=0x8000_1001, `exu_imm`=0x3 -> raw sum 0x8000_1004 with bit0 already clear -> `ifu_pc`=0x8000_1004. With `exu_rs1`=0x8000_1001, `exu_imm`=0 -> 0x8000_1000.
- Misalign: pc=0x8000_0000, `pca_src`=1, `pcb_src`=0, `exu_imm`=0x6 -> `misalign`=1, `misalign_pc`=0x8000_0006, `ifu_valid`=0 and `exu_ready`=0 for all following cycles, `retire_cnt` unchanged.
- Reset asserted in a WAIT cycle concurrent with `exu_valid`=1, and again while in HALT -> next cycle `ifu_pc`=`RESET_PC`, `ifu_valid`=1, `misalign`=0, `retire_cnt`=0.

Source files
------------

// File: rtl/pc_update.sv
// pc_update: program counter register and next-PC stage.
// Hands each PC to fetch, waits for the execute result, detects misaligned targets, counts retirements.
module pc_update #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clock,
   input  logic            reset,
   output logic            ifu_valid,
   input  logic            ifu_ready,
   output logic [XLEN-1:0] ifu_pc,
   input  logic            exu_valid,
   output logic            exu_ready,
   input  logic            pca_src,
   input  logic            pcb_src,
   input  logic [XLEN-1:0] exu_imm,
   input  logic [XLEN-1:0] exu_rs1,
   output logic            misalign,
   output logic [XLEN-1:0] misalign_pc,
   output logic [63:0]     retire_cnt
);
   typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HALT} state_t;
   state_t          r_state, w_next;
   logic [XLEN-1:0] r_pc, r_misalign_pc, w_sum, w_target;
   logic [63:0]     r_retire_cnt;
   logic            r_misalign, w_commit, w_aligned;
   // Register-indirect jumps drop bit 0 after the add, before the alignment test.
   assign w_sum     = (pca_src ? exu_imm : XLEN'(4)) + (pcb_src ? exu_rs1 : r_pc);
   assign w_target  = {w_sum[XLEN-1:1], w_sum[0] & ~pcb_src};
   assign w_aligned = w_target[1:0] == 2'b00;
   assign w_commit  = r_state == S_WAIT && exu_valid;
   always_ff @(posedge clock) begin
      r_state <= reset ? S_ISSUE : w_next;
   end
   always_comb begin
      w_next = (r_state == S_ISSUE && ifu_ready) ? S_WAIT :
               w_commit ? (w_aligned ? S_ISSUE : S_HALT) : r_state;
   end
   always_comb begin
      ifu_valid = !reset && r_state == S_ISSUE;
      exu_ready = !reset && r_state == S_WAIT;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_misalign    <= 1'b0;
         r_misalign_pc <= '0;
         r_retire_cnt  <= '0;
      end else if (w_commit && w_aligned) begin
         r_pc         <= w_target;
         r_retire_cnt <= r_retire_cnt + 64'd1;
      end else if (w_commit) begin
         r_misalign    <= 1'b1;
         r_misalign_pc <= w_target;
      end
   end
   assign ifu_pc      = r_pc;
   assign misalign    = r_misalign;
   assign misalign_pc = r_misalign_pc;
   assign retire_cnt  = r_retire_cnt;
endmodule

// File: tb/tb_pc_update.sv
// tb_pc_update: directed steps with a queue of expected fetch PCs checked at each fetch handshake.
module tb_pc_update;
   localparam logic [31:0] RPC = 32'h8000_0000;
   logic        clock = 1'b0, reset = 1'b1;
   logic        ifu_valid, ifu_ready = 1'b0, exu_valid = 1'b0, exu_ready;
   logic        pca_src = 1'b0, pcb_src = 1'b0, misalign;
   logic [31:0] ifu_pc, exu_imm = '0, exu_rs1 = '0, misalign_pc;
   logic [63:0] retire_cnt;
   logic [31:0] exp_q[$];
   logic [31:0] m_pc;
   logic [63:0] m_cnt;
   int          checks = 0, errors = 0;

   pc_update dut (
      .clock(clock), .reset(reset), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
      .ifu_pc(ifu_pc), .exu_valid(exu_valid), .exu_ready(exu_ready),
      .pca_src(pca_src), .pcb_src(pcb_src), .exu_imm(exu_imm), .exu_rs1(exu_rs1),
      .misalign(misalign), .misalign_pc(misalign_pc), .retire_cnt(retire_cnt)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pops the expected PC when fetch accepts it; leaves the stage in WAIT.
   task automatic fetch(input string tag);
      int n = 0;
      ifu_ready = 1'b1;
      while (!ifu_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!ifu_valid || exp_q.size() == 0) begin
         chk({tag, "_handshake"}, {63'd0, ifu_valid}, 64'd1);
         chk({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
      end else chk(tag, {32'd0, ifu_pc}, {32'd0, exp_q.pop_front()});
      @(negedge clock);
      ifu_ready = 1'b0;
   endtask

   task automatic exec(input string tag, input logic a, input logic b,
                       input logic [31:0] imm, input logic [31:0] rs1);
      logic [31:0] t;
      chk({tag, "_exu_ready"}, {63'd0, exu_ready}, 64'd1);
      t = (a ? imm : 32'd4) + (b ? rs1 : m_pc);
      if (b) t[0] = 1'b0;
      pca_src = a; pcb_src = b; exu_imm = imm; exu_rs1 = rs1; exu_valid = 1'b1;
      @(negedge clock);
      exu_valid = 1'b0;
      if (t[1:0] == 2'b00) begin
         m_pc = t;
         m_cnt++;
         exp_q.push_back(t);
      end else begin
         chk({tag, "_misalign"}, {63'd0, misalign}, 64'd1);
         chk({tag, "_misalign_pc"}, {32'd0, misalign_pc}, {32'd0, t});
      end
      chk({tag, "_retire"}, retire_cnt, m_cnt);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ifu_valid"}, {63'd0, ifu_valid}, 64'd1);
      chk({tag, "_pc"}, {32'd0, ifu_pc}, {32'd0, RPC});
      chk({tag, "_misalign"}, {63'd0, misalign}, 64'd0);
      chk({tag, "_misalign_pc"}, {32'd0, misalign_pc}, 64'd0);
      chk({tag, "_retire"}, retire_cnt, 64'd0);
      m_pc = RPC;
      m_cnt = 0;
      exp_q.delete();
      exp_q.push_back(RPC);
   endtask

   initial begin
      // reset
      @(negedge clock);
      @(negedge clock);
      chk("rst_ifu_valid", {63'd0, ifu_valid}, 64'd0);
      chk("rst_exu_ready", {63'd0, exu_ready}, 64'd0);
      reset = 1'b0;
      #1;
      check_reset_state("after_rst");
      @(negedge clock);
      // streaming with both partners always ready: one new PC every 2 cycles
      ifu_ready = 1'b1; exu_valid = 1'b1; pca_src = 1'b0; pcb_src = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stream_valid", {63'd0, ifu_valid}, 64'd1);
         chk("stream_pc", {32'd0, ifu_pc}, {32'd0, exp_q.pop_front()});
         m_pc += 32'd4;
         m_cnt++;
         exp_q.push_back(m_pc);
         @(negedge clock);
         chk("stream_wait_valid", {63'd0, ifu_valid}, 64'd0);
         chk("stream_wait_ready", {63'd0, exu_ready}, 64'd1);
         @(negedge clock);
      end
      chk("stream_retire", retire_cnt, 64'd3);
      // fetch backpressure with stray exu_valid pulses
      ifu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exu_valid = i[0];
         chk("bp_valid", {63'd0, ifu_valid}, 64'd1);
         chk("bp_pc", {32'd0, ifu_pc}, {32'd0, m_pc});
         chk("bp_exu_ready", {63'd0, exu_ready}, 64'd0);
         @(negedge clock);
      end
      exu_valid = 1'b0;
      fetch("bp_fetch");
      // taken branch backwards
      exec("seq", 1'b0, 1'b0, 32'd0, 32'd0);
      fetch("seq_fetch");
      exec("branch", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0);
      fetch("branch_fetch");
      // wrap past all-ones
      exec("jump_top", 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFC);
      fetch("jump_top_fetch");
      exec("wrap", 1'b0, 1'b0, 32'd0, 32'd0);
      fetch("wrap_fetch");
      // register-indirect jumps
      exec("ind_a", 1'b1, 1'b1, 32'd3, 32'h8000_1001);
      fetch("ind_a_fetch");
      exec("ind_b", 1'b1, 1'b1, 32'd0, 32'h8000_1001);
      fetch("ind_b_fetch");
      // reset in WAIT with a coincident exu_valid
      reset = 1'b1; exu_valid = 1'b1; pca_src = 1'b1; exu_imm = 32'd4;
      @(negedge clock);
      chk("rstw_ifu_valid", {63'd0, ifu_valid}, 64'd0);
      chk("rstw_exu_ready", {63'd0, exu_ready}, 64'd0);
      reset = 1'b0; exu_valid = 1'b0;
      #1;
      check_reset_state("rstw");
      fetch("rstw_fetch");
      // misaligned branch target halts the stage
      exec("mis", 1'b1, 1'b0, 32'd6, 32'd0);
      ifu_ready = 1'b1; exu_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("halt_ifu_valid", {63'd0, ifu_valid}, 64'd0);
         chk("halt_exu_ready", {63'd0, exu_ready}, 64'd0);
         chk("halt_pc", {32'd0, ifu_pc}, {32'd0, RPC});
         @(negedge clock);
      end
      chk("halt_retire", retire_cnt, 64'd0);
      chk("halt_misalign_pc", {32'd0, misalign_pc}, 64'h8000_0006);
      // reset out of HALT
      ifu_ready = 1'b0; exu_valid = 1'b0; reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_reset_state("rsth");
      fetch("rsth_fetch");
      exec("rsth_seq", 1'b0, 1'b0, 32'd0, 32'd0);
      fetch("rsth_seq_fetch");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
